cache_controller: RTL and testbench

Sequencing FSM for the integrated data cache of the single-cycle RISC-V core. It takes the core's memory-access strobes (MemRead/MemWrite from the control unit) and the tag-compare hit flag. It stalls the core on misses and writes, drives a ready-handshaked main-memory port, and steers block refills into the data/tag arrays. Policy: direct-mapped, write-through, no-write-allocate. It also keeps saturating hit/miss counters for bring-up.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_controller_refill_counter.sv | 28 ++
 rtl/cache_controller.sv | 136 +++++++++++++
 tb/tb_cache_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache sequencing logic and its tag/data arrays.
package cache_pkg;

  localparam int unsigned WPB_DEFAULT   = 4;
  localparam int unsigned OFF_W_DEFAULT = $clog2(WPB_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    REFILL = 2'd2,
    RESUME = 2'd3
  } state_e;

  // Word-offset width for a block of wpb words.
  function automatic int unsigned off_w(input int unsigned wpb);
    return $clog2(wpb);
  endfunction

endpackage

// File: rtl/cache_controller_refill_counter.sv
// Word counter that walks the block offset during a refill burst.
module refill_counter
  import cache_pkg::*;
#(
  parameter int unsigned WPB   = WPB_DEFAULT,
  parameter int unsigned OFF_W = off_w(WPB)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [OFF_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + OFF_W'(1);
    end
  end

  assign last = (count == OFF_W'(WPB - 1));

endmodule

// File: rtl/cache_controller.sv
// Data-cache sequencer: write-through, no-write-allocate, direct-mapped; stalls
// the core on misses and writes and drives the main-memory word handshake.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned WPB   = WPB_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic                    Hit,
  input  logic                    mem_ready,
  output logic                    Stall,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [$clog2(WPB)-1:0]  mem_word,
  output logic                    refill_we,
  output logic                    tag_we,
  output logic                    cache_wr_en,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int unsigned OFF_W = off_w(WPB);

  state_e           state_q, state_d;
  logic             hit_q, hit_d;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             hit_inc, miss_inc;
  logic [OFF_W-1:0] word_cnt;

  refill_counter #(
    .WPB   (WPB),
    .OFF_W (OFF_W)
  ) u_refill_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (word_cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  // Bring-up counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc && (hit_cnt != {CNT_W{1'b1}})) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // Stall in IDLE is Mealy so the core never advances on the miss/write cycle.
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    Stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_word    = '0;
    refill_we   = 1'b0;
    tag_we      = 1'b0;
    cache_wr_en = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemWrite) begin
          Stall   = 1'b1;
          hit_d   = Hit;
          state_d = WRITE;
        end else if (MemRead && !Hit) begin
          Stall    = 1'b1;
          cnt_clr  = 1'b1;
          miss_inc = 1'b1;
          state_d  = REFILL;
        end else if (MemRead) begin
          hit_inc = 1'b1;
        end
      end

      WRITE: begin
        Stall  = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          cache_wr_en = hit_q;
          state_d     = RESUME;
        end
      end

      REFILL: begin
        Stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_word = word_cnt;
        if (mem_ready) begin
          refill_we = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            tag_we  = 1'b1;
            state_d = RESUME;
          end
        end
      end

      RESUME: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller (WPB=4, CNT_W=4): directed per-cycle vectors.
module tb_cache_controller;

  localparam int unsigned WPB   = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             MemRead, MemWrite, Hit, mem_ready;
  logic             Stall, mem_rd, mem_wr, refill_we, tag_we, cache_wr_en;
  logic [1:0]       mem_word;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  typedef struct {
    string      name;
    logic [5:0] o;   // {Stall, mem_rd, mem_wr, refill_we, tag_we, cache_wr_en}
    logic [1:0] w;
    logic [3:0] hc;
    logic [3:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  cache_controller #(
    .WPB   (WPB),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Hit         (Hit),
    .mem_ready   (mem_ready),
    .Stall       (Stall),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_word    (mem_word),
    .refill_we   (refill_we),
    .tag_we      (tag_we),
    .cache_wr_en (cache_wr_en),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expected vector per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    logic [5:0] act_o;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        act_o = {Stall, mem_rd, mem_wr, refill_we, tag_we, cache_wr_en};
        total++;
        if (act_o !== e.o || mem_word !== e.w || hit_cnt !== e.hc || miss_cnt !== e.mc) begin
          bad++;
          $display("FAIL %s: got o=%b w=%0d hit=%0d miss=%0d, want o=%b w=%0d hit=%0d miss=%0d",
                   e.name, act_o, mem_word, hit_cnt, miss_cnt, e.o, e.w, e.hc, e.mc);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input string nm, input logic rs, input logic mr, input logic mw,
                      input logic h, input logic rdy, input logic [5:0] o,
                      input logic [1:0] w, input int hc, input int mc);
    exp_t e;
    rst_n     = rs;
    MemRead   = mr;
    MemWrite  = mw;
    Hit       = h;
    mem_ready = rdy;
    e.name = $sformatf("%s#%0d", nm, vec);
    e.o    = o;
    e.w    = w;
    e.hc   = 4'(hc);
    e.mc   = 4'(mc);
    vec++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Hit = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, ready in IDLE ignored
    step("reset",   0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("idle",    1, 0, 0, 0, 1, 6'b000000, 0, 0, 0);

    // Read hits
    step("rhit",    1, 1, 0, 1, 0, 6'b000000, 0, 0, 0);
    step("rhit",    1, 1, 0, 1, 0, 6'b000000, 0, 1, 0);
    step("rhit",    1, 1, 0, 1, 0, 6'b000000, 0, 2, 0);
    step("rhit_end",1, 0, 0, 0, 0, 6'b000000, 0, 3, 0);

    // Read miss, memory always ready
    step("miss",    1, 1, 0, 0, 0, 6'b100000, 0, 3, 0);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 0, 3, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 1, 3, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 2, 3, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110110, 3, 3, 1);
    step("resume",  1, 1, 0, 1, 1, 6'b000000, 0, 3, 1);
    step("idle",    1, 0, 0, 0, 0, 6'b000000, 0, 3, 1);

    // Write hit, ready delayed 3 cycles
    step("whit",    1, 0, 1, 1, 0, 6'b100000, 0, 3, 1);
    step("wwait",   1, 0, 1, 0, 0, 6'b101000, 0, 3, 1);
    step("wwait",   1, 0, 1, 0, 0, 6'b101000, 0, 3, 1);
    step("wwait",   1, 0, 1, 0, 0, 6'b101000, 0, 3, 1);
    step("wdone",   1, 0, 1, 0, 1, 6'b101001, 0, 3, 1);
    step("resume",  1, 0, 1, 1, 1, 6'b000000, 0, 3, 1);

    // Write miss; Hit toggled during WRITE must not matter
    step("wmiss",   1, 0, 1, 0, 0, 6'b100000, 0, 3, 1);
    step("wwait",   1, 0, 1, 1, 0, 6'b101000, 0, 3, 1);
    step("wwait",   1, 0, 1, 1, 0, 6'b101000, 0, 3, 1);
    step("wwait",   1, 0, 1, 1, 0, 6'b101000, 0, 3, 1);
    step("wdone",   1, 0, 1, 1, 1, 6'b101000, 0, 3, 1);
    step("resume",  1, 0, 1, 1, 1, 6'b000000, 0, 3, 1);

    // Both strobes with a miss: write wins, no refill, miss count unchanged
    step("both",    1, 1, 1, 0, 0, 6'b100000, 0, 3, 1);
    step("bwrite",  1, 1, 1, 0, 1, 6'b101000, 0, 3, 1);
    step("bresume", 1, 1, 1, 0, 1, 6'b000000, 0, 3, 1);
    step("idle",    1, 0, 0, 0, 0, 6'b000000, 0, 3, 1);

    // Reset in the middle of a refill
    step("miss2",   1, 1, 0, 0, 0, 6'b100000, 0, 3, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 0, 3, 2);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 1, 3, 2);
    step("rst_mid", 0, 1, 0, 0, 0, 6'b110000, 2, 3, 2);
    step("post_rst",1, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Fresh miss restarts at word 0, with one wait state
    step("miss3",   1, 1, 0, 0, 0, 6'b100000, 0, 0, 0);
    step("rwait",   1, 1, 0, 0, 0, 6'b110000, 0, 0, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 0, 0, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 1, 0, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110100, 2, 0, 1);
    step("refill",  1, 1, 0, 0, 1, 6'b110110, 3, 0, 1);
    step("resume",  1, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

    // Hit counter saturation at 15
    for (int i = 0; i < 18; i++) begin
      step("sat", 1, 1, 0, 1, 0, 6'b000000, 0, (i > 15) ? 15 : i, 1);
    end
    step("sat_hold",1, 0, 0, 0, 0, 6'b000000, 0, 15, 1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
